// File: rtl/perf_pkg.sv
// Shared definitions for the performance-counter / run-control block.
// Latency: n/a (package only).
// Backpressure: n/a.
package perf_pkg;

    // Register word offsets, i.e. bus_addr_i[5:2]
    localparam logic [3:0] REG_CTRL    = 4'h0;  // 0x00
    localparam logic [3:0] REG_STATUS  = 4'h1;  // 0x04
    localparam logic [3:0] REG_TOHOST  = 4'h2;  // 0x08
    localparam logic [3:0] REG_CYC_LO  = 4'h4;  // 0x10
    localparam logic [3:0] REG_CYC_HI  = 4'h5;  // 0x14
    localparam logic [3:0] REG_INS_LO  = 4'h6;  // 0x18
    localparam logic [3:0] REG_INS_HI  = 4'h7;  // 0x1C
    localparam logic [3:0] REG_BR_LO   = 4'h8;  // 0x20
    localparam logic [3:0] REG_BR_HI   = 4'h9;  // 0x24
    localparam logic [3:0] REG_MISP_LO = 4'hA;  // 0x28
    localparam logic [3:0] REG_MISP_HI = 4'hB;  // 0x2C

    // CTRL write-data bit positions
    localparam int CTRL_RUN  = 0;
    localparam int CTRL_CLR  = 1;
    localparam int CTRL_SNAP = 2;

    localparam logic [31:0] PASS_CODE_DEF = 32'h0000_0777;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    // Picks the lo or hi 32-bit half of a zero-extended counter snapshot.
    function automatic logic [31:0] word_sel(input logic [63:0] v, input logic hi);
        return hi ? v[63:32] : v[31:0];
    endfunction

endpackage

// File: rtl/perf_counter.sv
// One event counter with a live register and a snapshot register.
// Latency: live and snapshot update on the clock edge after the inputs.
// Backpressure: none; counts every qualified event.
//
// Ports: clk_i/rst_i clock and sync reset; en_i counting enable; ev_i event;
//        clr_i zero the live count; snap_i capture into snap_o.
module perf_counter #(
    parameter int CNT_W = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             ev_i,
    input  logic             clr_i,
    input  logic             snap_i,
    output logic [CNT_W-1:0] snap_o
);

    logic [CNT_W-1:0] live_q, live_d;
    logic [CNT_W-1:0] snap_q, snap_d;
    logic [CNT_W-1:0] live_inc;
    logic             bump;

    assign bump     = en_i & ev_i;
    // Natural wrap at 2^CNT_W-1 -> 0; no overflow flag is kept.
    assign live_inc = live_q + {{(CNT_W-1){1'b0}}, bump};

    always_comb begin
        live_d = clr_i ? '0 : live_inc;
        // The snapshot sees this cycle's event but not a clear issued in the
        // same write, so snap+clear captures the pre-clear total.
        snap_d = snap_i ? live_inc : snap_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            live_q <= '0;
            snap_q <= '0;
        end else begin
            live_q <= live_d;
            snap_q <= snap_d;
        end
    end

    assign snap_o = snap_q;

endmodule

// File: rtl/perf_ctrl.sv
// Memory-mapped performance counters plus run/halt control with TOHOST pass/fail.
// Latency: writes take effect at the next edge; reads return one cycle after bus_rreq_i.
// Backpressure: none; every selected read gets a response strobe the following cycle.
//
// Ports: clk_i/rst_i; bus_addr_i/bus_wvalid_i/bus_wdata_i write side;
//        bus_rreq_i/bus_rdata_o/bus_rvalid_o read side; ev_retire_i/ev_br_i/ev_misp_i
//        event inputs; running_o/done_o/pass_o run status.
// Build option: define PERF_BRANCH_CNT_EN to build the BR and MISP counters.
module perf_ctrl
    import perf_pkg::*;
#(
    parameter int          CNT_W     = 64,
    parameter int          SEL_BIT   = 18,
    parameter logic [31:0] PASS_CODE = PASS_CODE_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] bus_addr_i,
    input  logic        bus_wvalid_i,
    input  logic [31:0] bus_wdata_i,
    input  logic        bus_rreq_i,
    output logic [31:0] bus_rdata_o,
    output logic        bus_rvalid_o,
    input  logic        ev_retire_i,
    input  logic        ev_br_i,
    input  logic        ev_misp_i,
    output logic        running_o,
    output logic        done_o,
    output logic        pass_o
);

    state_e      state_q, state_d;
    logic        pass_q, pass_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;

    logic        sel;
    logic [3:0]  off;
    logic        ctrl_wr, tohost_wr, rd_req;
    logic        cnt_en, cnt_clr, cnt_snap;
    logic [31:0] rd_word;

    logic [CNT_W-1:0] cyc_snap, ins_snap;

    assign sel       = bus_addr_i[31] & bus_addr_i[SEL_BIT];
    assign off       = bus_addr_i[5:2];
    assign ctrl_wr   = sel & bus_wvalid_i & (off == REG_CTRL);
    assign tohost_wr = sel & bus_wvalid_i & (off == REG_TOHOST);
    assign rd_req    = sel & bus_rreq_i;

    // Counting follows the current state, so the TOHOST-write cycle itself
    // is still counted and counters freeze from the following edge.
    assign cnt_en   = (state_q == ST_RUN);
    assign cnt_clr  = ctrl_wr & bus_wdata_i[CTRL_CLR];
    assign cnt_snap = (ctrl_wr & bus_wdata_i[CTRL_SNAP]) | tohost_wr;

    // ------------------------------------------------------------------
    // Run-control FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        case (state_q)
            ST_IDLE: begin
                if (tohost_wr) begin
                    state_d = ST_HALT;
                    pass_d  = (bus_wdata_i == PASS_CODE);
                end else if (ctrl_wr && bus_wdata_i[CTRL_RUN]) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // TOHOST outranks a simultaneous CTRL write.
                if (tohost_wr) begin
                    state_d = ST_HALT;
                    pass_d  = (bus_wdata_i == PASS_CODE);
                end else if (ctrl_wr && !bus_wdata_i[CTRL_RUN]) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HALT: begin
                // Sticky until reset; the first TOHOST verdict is kept.
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
        end
    end

    // ------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------
    perf_counter #(.CNT_W(CNT_W)) u_cyc (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (cnt_en),
        .ev_i   (1'b1),
        .clr_i  (cnt_clr),
        .snap_i (cnt_snap),
        .snap_o (cyc_snap)
    );

    perf_counter #(.CNT_W(CNT_W)) u_ins (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (cnt_en),
        .ev_i   (ev_retire_i),
        .clr_i  (cnt_clr),
        .snap_i (cnt_snap),
        .snap_o (ins_snap)
    );

`ifdef PERF_BRANCH_CNT_EN
    logic [CNT_W-1:0] br_snap, misp_snap;

    perf_counter #(.CNT_W(CNT_W)) u_br (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (cnt_en),
        .ev_i   (ev_br_i),
        .clr_i  (cnt_clr),
        .snap_i (cnt_snap),
        .snap_o (br_snap)
    );

    // A misprediction only counts when it accompanies a resolved transfer.
    perf_counter #(.CNT_W(CNT_W)) u_misp (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (cnt_en),
        .ev_i   (ev_br_i & ev_misp_i),
        .clr_i  (cnt_clr),
        .snap_i (cnt_snap),
        .snap_o (misp_snap)
    );
`else
    logic unused_br;
    assign unused_br = ev_br_i ^ ev_misp_i;
`endif

    // Only a handful of address bits take part in decoding.
    logic unused_addr;
    assign unused_addr = ^bus_addr_i;

    // ------------------------------------------------------------------
    // Read path: the mux looks at registered state only, so a same-cycle
    // write is never visible to the read issued alongside it.
    // ------------------------------------------------------------------
    always_comb begin
        rd_word = '0;
        case (off)
            REG_STATUS:  rd_word = {29'b0, pass_q, (state_q == ST_HALT), (state_q == ST_RUN)};
            REG_CYC_LO:  rd_word = word_sel(64'(cyc_snap), 1'b0);
            REG_CYC_HI:  rd_word = word_sel(64'(cyc_snap), 1'b1);
            REG_INS_LO:  rd_word = word_sel(64'(ins_snap), 1'b0);
            REG_INS_HI:  rd_word = word_sel(64'(ins_snap), 1'b1);
`ifdef PERF_BRANCH_CNT_EN
            REG_BR_LO:   rd_word = word_sel(64'(br_snap), 1'b0);
            REG_BR_HI:   rd_word = word_sel(64'(br_snap), 1'b1);
            REG_MISP_LO: rd_word = word_sel(64'(misp_snap), 1'b0);
            REG_MISP_HI: rd_word = word_sel(64'(misp_snap), 1'b1);
`endif
            default:     rd_word = '0;
        endcase
    end

    always_comb begin
        rvalid_d = rd_req;
        rdata_d  = rd_req ? rd_word : 32'h0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign bus_rvalid_o = rvalid_q;
    assign bus_rdata_o  = rdata_q;
    assign running_o    = (state_q == ST_RUN);
    assign done_o       = (state_q == ST_HALT);
    assign pass_o       = pass_q;

endmodule

// File: tb/tb_perf_ctrl.sv
// Directed self-checking bench for perf_ctrl.
// Latency: n/a.
// Backpressure: n/a.
module tb_perf_ctrl;

    localparam logic [31:0] BASE = 32'h8004_0000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] bus_addr_i;
    logic        bus_wvalid_i;
    logic [31:0] bus_wdata_i;
    logic        bus_rreq_i;
    logic [31:0] bus_rdata_o;
    logic        bus_rvalid_o;
    logic        ev_retire_i;
    logic        ev_br_i;
    logic        ev_misp_i;
    logic        running_o;
    logic        done_o;
    logic        pass_o;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    perf_ctrl dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .bus_addr_i   (bus_addr_i),
        .bus_wvalid_i (bus_wvalid_i),
        .bus_wdata_i  (bus_wdata_i),
        .bus_rreq_i   (bus_rreq_i),
        .bus_rdata_o  (bus_rdata_o),
        .bus_rvalid_o (bus_rvalid_o),
        .ev_retire_i  (ev_retire_i),
        .ev_br_i      (ev_br_i),
        .ev_misp_i    (ev_misp_i),
        .running_o    (running_o),
        .done_o       (done_o),
        .pass_o       (pass_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // All tasks start and end on a falling edge.
    task automatic bus_wr(input logic [3:0] off, input logic [31:0] data);
        bus_addr_i   = BASE | {26'h0, off, 2'b00};
        bus_wdata_i  = data;
        bus_wvalid_i = 1'b1;
        @(negedge clk_i);
        bus_wvalid_i = 1'b0;
        bus_wdata_i  = 32'h0;
    endtask

    task automatic bus_rd(input logic [3:0] off, output logic [31:0] d);
        bus_addr_i = BASE | {26'h0, off, 2'b00};
        bus_rreq_i = 1'b1;
        @(negedge clk_i);
        bus_rreq_i = 1'b0;
        check("rvalid", {63'h0, bus_rvalid_o}, 64'h1);
        d = bus_rdata_o;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_i        = 1'b1;
        bus_wvalid_i = 1'b0;
        bus_rreq_i   = 1'b0;
        ev_retire_i  = 1'b0;
        ev_br_i      = 1'b0;
        ev_misp_i    = 1'b0;
        idle(2);
        rst_i = 1'b0;
    endtask

    logic [31:0] rd;
    logic [31:0] exp_br, exp_misp;

    initial begin
        bus_addr_i  = BASE;
        bus_wdata_i = 32'h0;
        @(negedge clk_i);
        do_reset();

        // ---- reset state ----
        check("rst_running", {63'h0, running_o}, 64'h0);
        check("rst_done",    {63'h0, done_o},    64'h0);
        check("rst_pass",    {63'h0, pass_o},    64'h0);
        check("rst_rvalid",  {63'h0, bus_rvalid_o}, 64'h0);
        check("rst_rdata",   {32'h0, bus_rdata_o},  64'h0);
        bus_rd(perf_pkg::REG_CYC_LO, rd);
        check("rst_cyc_lo", {32'h0, rd}, 64'h0);
        idle(1);
        check("rdata_idle_zero", {32'h0, bus_rdata_o}, 64'h0);

        // ---- unselected address and unmapped offset ----
        bus_addr_i = 32'h8000_0004;   // bit 18 clear
        bus_rreq_i = 1'b1;
        @(negedge clk_i);
        bus_rreq_i = 1'b0;
        check("unsel_rvalid", {63'h0, bus_rvalid_o}, 64'h0);
        bus_wr(4'h3, 32'h1);
        check("unmapped_wr_ignored", {63'h0, running_o}, 64'h0);
        bus_rd(4'h3, rd);
        check("unmapped_rd", {32'h0, rd}, 64'h0);

        // ---- test 1: run, idle 10, stop+snap ----
        // Counted edges: 10 idle + the snap write edge = 11.
        bus_wr(perf_pkg::REG_CTRL, 32'h1);
        check("t1_running", {63'h0, running_o}, 64'h1);
        idle(10);
        bus_wr(perf_pkg::REG_CTRL, 32'h4);
        check("t1_stopped", {63'h0, running_o}, 64'h0);
        bus_rd(perf_pkg::REG_CYC_LO, rd);
        check("t1_cyc_lo", {32'h0, rd}, 64'd11);
        bus_rd(perf_pkg::REG_CYC_HI, rd);
        check("t1_cyc_hi", {32'h0, rd}, 64'h0);

        // ---- test 2: retire 7, TOHOST pass ----
        // Cycles: 7 retire edges + TOHOST edge = 8.
        bus_wr(perf_pkg::REG_CTRL, 32'h3);
        ev_retire_i = 1'b1;
        idle(7);
        ev_retire_i = 1'b0;
        bus_wr(perf_pkg::REG_TOHOST, 32'h777);
        check("t2_done",    {63'h0, done_o},    64'h1);
        check("t2_pass",    {63'h0, pass_o},    64'h1);
        check("t2_running", {63'h0, running_o}, 64'h0);
        bus_rd(perf_pkg::REG_INS_LO, rd);
        check("t2_ins_lo", {32'h0, rd}, 64'd7);
        bus_rd(perf_pkg::REG_CYC_LO, rd);
        check("t2_cyc_lo", {32'h0, rd}, 64'd8);
        bus_rd(perf_pkg::REG_STATUS, rd);
        check("t2_status", {32'h0, rd}, 64'h6);
        idle(20);
        bus_wr(perf_pkg::REG_CTRL, 32'h4);   // snap still honoured in HALT
        bus_rd(perf_pkg::REG_CYC_LO, rd);
        check("t2_cyc_frozen", {32'h0, rd}, 64'd8);
        bus_wr(perf_pkg::REG_CTRL, 32'h1);   // run request ignored in HALT
        check("t2_halt_sticky", {63'h0, done_o}, 64'h1);

        // ---- test 3: TOHOST fail from IDLE ----
        do_reset();
        bus_wr(perf_pkg::REG_TOHOST, 32'h123);
        check("t3_done", {63'h0, done_o}, 64'h1);
        check("t3_pass", {63'h0, pass_o}, 64'h0);
        bus_rd(perf_pkg::REG_STATUS, rd);
        check("t3_status", {32'h0, rd}, 64'h2);

        // ---- test 4: cycle counter wrap ----
        // Preload 2^64-2, then 3 counted edges -> 1.
        do_reset();
        force dut.u_cyc.live_q = 64'hFFFF_FFFF_FFFF_FFFE;
        idle(1);
        release dut.u_cyc.live_q;
        bus_wr(perf_pkg::REG_CTRL, 32'h1);
        idle(2);
        bus_wr(perf_pkg::REG_CTRL, 32'h4);
        bus_rd(perf_pkg::REG_CYC_LO, rd);
        check("t4_wrap_lo", {32'h0, rd}, 64'd1);
        bus_rd(perf_pkg::REG_CYC_HI, rd);
        check("t4_wrap_hi", {32'h0, rd}, 64'd0);

        // ---- test 5: clear vs event, snap+clear ----
        do_reset();
        bus_wr(perf_pkg::REG_CTRL, 32'h1);
        ev_retire_i = 1'b1;
        idle(3);
        bus_wr(perf_pkg::REG_CTRL, 32'h3);   // clear with retire high: ends at 0
        ev_retire_i = 1'b0;
        bus_wr(perf_pkg::REG_CTRL, 32'h5);
        bus_rd(perf_pkg::REG_INS_LO, rd);
        check("t5_clear_wins", {32'h0, rd}, 64'd0);
        ev_retire_i = 1'b1;
        idle(4);
        ev_retire_i = 1'b0;
        bus_wr(perf_pkg::REG_CTRL, 32'h7);   // snap captures pre-clear 4
        bus_rd(perf_pkg::REG_INS_LO, rd);
        check("t5_snap_preclr", {32'h0, rd}, 64'd4);
        bus_wr(perf_pkg::REG_CTRL, 32'h5);
        bus_rd(perf_pkg::REG_INS_LO, rd);
        check("t5_after_clr", {32'h0, rd}, 64'd0);

        // ---- branch counters: br 3, misp 2 when built, else 0 ----
`ifdef PERF_BRANCH_CNT_EN
        exp_br   = 32'd3;
        exp_misp = 32'd2;
`else
        exp_br   = 32'd0;
        exp_misp = 32'd0;
`endif
        ev_br_i = 1'b1; ev_misp_i = 1'b1; idle(2);
        ev_br_i = 1'b1; ev_misp_i = 1'b0; idle(1);
        ev_br_i = 1'b0; ev_misp_i = 1'b1; idle(1);
        ev_misp_i = 1'b0;
        bus_wr(perf_pkg::REG_CTRL, 32'h5);
        bus_rd(perf_pkg::REG_BR_LO, rd);
        check("br_lo", {32'h0, rd}, {32'h0, exp_br});
        bus_rd(perf_pkg::REG_MISP_LO, rd);
        check("misp_lo", {32'h0, rd}, {32'h0, exp_misp});

        // ---- test 6: reset mid-run with a read pending ----
        idle(5);
        bus_addr_i = BASE | {26'h0, perf_pkg::REG_STATUS, 2'b00};
        bus_rreq_i = 1'b1;
        rst_i      = 1'b1;
        @(negedge clk_i);
        bus_rreq_i = 1'b0;
        rst_i      = 1'b0;
        check("t6_no_rvalid", {63'h0, bus_rvalid_o}, 64'h0);
        check("t6_running",   {63'h0, running_o},    64'h0);
        bus_rd(perf_pkg::REG_CYC_LO, rd);
        check("t6_cyc_snap", {32'h0, rd}, 64'h0);
        bus_wr(perf_pkg::REG_CTRL, 32'h4);
        bus_rd(perf_pkg::REG_INS_LO, rd);
        check("t6_ins_live", {32'h0, rd}, 64'h0);
        bus_rd(perf_pkg::REG_STATUS, rd);
        check("t6_status", {32'h0, rd}, 64'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
